ram_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port 2048x32 RAM.
- Requester A is instruction fetch; requester B is load/store.
- Owns the RAM's address, data_in, we and chip_select pins and captures the RAM's data_out.
- Round-robin arbitration with a registered req/ack handshake; each granted access takes a fixed 3 cycles.

---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the 2048x32 RAM.
// The master side is the arbiter; the slave side is requesters plus RAM.
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
);
   logic                  a_req;
   logic                  a_we;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic                  a_ack;
   logic [DATA_WIDTH-1:0] a_rdata;
   logic                  b_req;
   logic                  b_we;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_wdata;
   logic                  b_ack;
   logic [DATA_WIDTH-1:0] b_rdata;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic                  ram_we;
   logic                  ram_chip_select;
   logic [DATA_WIDTH-1:0] ram_data_out;

   modport master (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rdata,
      output busy,
      output ram_address, ram_data_in, ram_we, ram_chip_select,
      input  ram_data_out
   );

   modport slave (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rdata,
      input  busy,
      input  ram_address, ram_data_in, ram_we, ram_chip_select,
      output ram_data_out
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-requester sequencer for a single-port RAM.
// Each grant runs IDLE -> ACCESS -> ACK, one cycle per state.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
) (
   input  logic          clock,
   input  logic          reset,
   ram_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state;
   logic                  r_last_b, w_last_b;
   logic                  r_gnt_b, w_gnt_b;
   logic                  r_busy, w_busy;
   logic                  r_a_ack, w_a_ack;
   logic                  r_b_ack, w_b_ack;
   logic                  r_cs, w_cs;
   logic                  r_we, w_we;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
   logic [DATA_WIDTH-1:0] r_a_rdata, w_a_rdata;
   logic [DATA_WIDTH-1:0] r_b_rdata, w_b_rdata;
   logic                  w_pick_b;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_last_b  <= 1'b1;
         r_gnt_b   <= 1'b0;
         r_busy    <= 1'b0;
         r_a_ack   <= 1'b0;
         r_b_ack   <= 1'b0;
         r_cs      <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_a_rdata <= '0;
         r_b_rdata <= '0;
      end else begin
         r_state   <= w_state;
         r_last_b  <= w_last_b;
         r_gnt_b   <= w_gnt_b;
         r_busy    <= w_busy;
         r_a_ack   <= w_a_ack;
         r_b_ack   <= w_b_ack;
         r_cs      <= w_cs;
         r_we      <= w_we;
         r_addr    <= w_addr;
         r_wdata   <= w_wdata;
         r_a_rdata <= w_a_rdata;
         r_b_rdata <= w_b_rdata;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_last_b  = r_last_b;
      w_gnt_b   = r_gnt_b;
      w_busy    = r_busy;
      w_a_ack   = 1'b0;
      w_b_ack   = 1'b0;
      w_cs      = r_cs;
      w_we      = r_we;
      w_addr    = r_addr;
      w_wdata   = r_wdata;
      w_a_rdata = r_a_rdata;
      w_b_rdata = r_b_rdata;
      // B wins only when A is absent or A was served last
      w_pick_b  = bus.b_req & ~(bus.a_req & r_last_b);
      unique case (r_state)
         IDLE: begin
            w_cs = 1'b0;
            w_we = 1'b0;
            if (bus.a_req | bus.b_req) begin
               w_gnt_b  = w_pick_b;
               w_last_b = w_pick_b;
               w_addr   = w_pick_b ? bus.b_addr  : bus.a_addr;
               w_wdata  = w_pick_b ? bus.b_wdata : bus.a_wdata;
               w_we     = w_pick_b ? bus.b_we    : bus.a_we;
               w_cs     = 1'b1;
               w_busy   = 1'b1;
               w_state  = ACCESS;
            end
         end
         ACCESS: begin
            w_cs = 1'b0;
            w_we = 1'b0;
            // chip select is still high here, so the bus is driven
            if (!r_we) begin
               if (r_gnt_b) w_b_rdata = bus.ram_data_out;
               else         w_a_rdata = bus.ram_data_out;
            end
            w_a_ack = ~r_gnt_b;
            w_b_ack = r_gnt_b;
            w_state = ACK;
         end
         ACK: begin
            w_busy  = 1'b0;
            w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end

   assign bus.a_ack           = r_a_ack;
   assign bus.b_ack           = r_b_ack;
   assign bus.a_rdata         = r_a_rdata;
   assign bus.b_rdata         = r_b_rdata;
   assign bus.busy            = r_busy;
   assign bus.ram_address     = r_addr;
   assign bus.ram_data_in     = r_wdata;
   assign bus.ram_we          = r_we;
   assign bus.ram_chip_select = r_cs;
endmodule
